// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - RV32I fetch program counter with stall, trap/EPC, misaligned-target trap and return-address stack
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            enl,
  input  logic [XLEN-1:0] load,
  input  logic            trap,
  input  logic            trap_ret,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(RAS_DEPTH);

  if (RESET_VECTOR[1:0] != 2'b00 || TRAP_VECTOR[1:0] != 2'b00 ||
      RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
    $error("pc_gen: vectors must be 4-byte aligned and RAS_DEPTH a power of two >= 2");
  end

  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   occ_q, occ_d;

  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   ptr_inc;
  logic            load_misaligned;
  logic            ras_en;

  assign seq_pc          = count_q + XLEN'(4);
  assign ptr_inc         = ptr_q + PW'(1);
  assign load_misaligned = enl && (load[1:0] != 2'b00);
  // Any redirect that is not an ordinary jump leaves the stack untouched.
  assign ras_en          = !stall && !trap && !trap_ret && !load_misaligned;

  always_comb begin
    count_d      = count_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    if (trap) begin
      count_d = TRAP_VECTOR;
      epc_d   = count_q;
    end else if (trap_ret) begin
      count_d = epc_q;
    end else if (load_misaligned) begin
      count_d      = TRAP_VECTOR;
      epc_d        = count_q;
      misaligned_d = 1'b1;
    end else if (enl) begin
      count_d = load;
    end else if (!stall) begin
      count_d = seq_pc;
    end
  end

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    occ_d = occ_q;
    if (ras_en) begin
      if (call && ret && occ_q != '0) begin
        ras_d[ptr_q] = seq_pc;
      end else if (call) begin
        // When full the write lands on the oldest entry, so occupancy saturates.
        ras_d[ptr_inc] = seq_pc;
        ptr_d          = ptr_inc;
        if (occ_q != OCC_FULL) begin
          occ_d = occ_q + OW'(1);
        end
      end else if (ret && occ_q != '0) begin
        ptr_d = ptr_q - PW'(1);
        occ_d = occ_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      ptr_q        <= '0;
      occ_q        <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      count_q      <= count_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      ptr_q        <= ptr_d;
      occ_q        <= occ_d;
      ras_q        <= ras_d;
    end
  end

  assign count      = count_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;
  assign ras_empty  = (occ_q == '0);
  assign ras_full   = (occ_q == OCC_FULL);
  assign ras_top    = ras_empty ? '0 : ras_q[ptr_q];

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen against a queue-based reference model
module tb_pc_gen;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, enl = 1'b0, trap = 1'b0, trap_ret = 1'b0;
  logic        call = 1'b0, ret = 1'b0;
  logic [31:0] load = '0;
  logic [31:0] count, epc, ras_top;
  logic        misaligned, ras_empty, ras_full;

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .enl(enl), .load(load),
    .trap(trap), .trap_ret(trap_ret), .call(call), .ret(ret),
    .count(count), .epc(epc), .misaligned(misaligned),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_count, m_epc;
  logic        m_mis;
  logic [31:0] m_ras [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = RV;
    m_epc   = '0;
    m_mis   = 1'b0;
    m_ras.delete();
  endtask

  // Applies the current inputs to the reference state as one clock edge would.
  task automatic model_step();
    logic        bad_tgt;
    logic        ras_ok;
    logic [31:0] ret_addr;
    bad_tgt  = enl && (load % 4 != 0);
    ras_ok   = !stall && !trap && !trap_ret && !bad_tgt;
    ret_addr = m_count + 32'd4;
    if (ras_ok) begin
      if (call && ret && m_ras.size() != 0) begin
        m_ras[m_ras.size() - 1] = ret_addr;
      end else if (call) begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end else if (ret && m_ras.size() != 0) begin
        m_ras.delete(m_ras.size() - 1);
      end
    end
    m_mis = 1'b0;
    if (trap) begin
      m_epc   = m_count;
      m_count = TV;
    end else if (trap_ret) begin
      m_count = m_epc;
    end else if (bad_tgt) begin
      m_epc   = m_count;
      m_count = TV;
      m_mis   = 1'b1;
    end else if (enl) begin
      m_count = load;
    end else if (!stall) begin
      m_count = ret_addr;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_top;
    exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1];
    check({tag, ".count"}, count, m_count);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".misaligned"}, 32'(misaligned), 32'(m_mis));
    check({tag, ".ras_top"}, ras_top, exp_top);
    check({tag, ".ras_empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    check({tag, ".ras_full"}, 32'(ras_full), 32'(m_ras.size() == DEPTH));
  endtask

  task automatic idle_inputs();
    stall = 1'b0; enl = 1'b0; trap = 1'b0; trap_ret = 1'b0;
    call = 1'b0; ret = 1'b0; load = '0;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  // Called one time unit after a rising edge; asserts reset between edges.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, ".count_immediate"}, count, RV);
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    for (int i = 0; i < 4; i++) cycle("seq");
    check("seq_end", count, 32'h10);

    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      cycle("stall");
    end
    check("stall_hold", count, 32'h10);
    stall = 1'b1; enl = 1'b1; load = 32'h200;
    cycle("stall_enl");
    check("stall_enl_target", count, 32'h200);

    enl = 1'b1; load = 32'h40;
    cycle("goto40");
    enl = 1'b1; load = 32'h102;
    cycle("mis");
    check("mis_count", count, 32'h100);
    check("mis_epc", epc, 32'h40);
    check("mis_pulse", 32'(misaligned), 32'd1);
    trap_ret = 1'b1;
    cycle("tret");
    check("tret_count", count, 32'h40);
    check("mis_cleared", 32'(misaligned), 32'd0);

    enl = 1'b1; load = 32'h20;
    cycle("goto20");
    trap = 1'b1; enl = 1'b1; load = 32'h80;
    cycle("trap_enl");
    check("trap_count", count, 32'h100);
    check("trap_epc", epc, 32'h20);

    async_reset("rst_ras");
    for (int i = 0; i < 5; i++) begin
      call = 1'b1;
      cycle("call");
    end
    check("ras_full5", 32'(ras_full), 32'd1);
    check("ras_top5", ras_top, 32'h14);
    ret = 1'b1; cycle("ret1"); check("ret1_top", ras_top, 32'h10);
    ret = 1'b1; cycle("ret2"); check("ret2_top", ras_top, 32'hC);
    ret = 1'b1; cycle("ret3"); check("ret3_top", ras_top, 32'h8);
    ret = 1'b1; cycle("ret4"); check("ret4_empty", 32'(ras_empty), 32'd1);
    ret = 1'b1; cycle("ret5"); check("ret5_empty", 32'(ras_empty), 32'd1);

    enl = 1'b1; load = 32'hFFFF_FFF8;
    cycle("goto_top");
    cycle("wrap1");
    check("wrap1_count", count, 32'hFFFF_FFFC);
    cycle("wrap2");
    check("wrap2_count", count, 32'h0);
    cycle("wrap3");
    async_reset("rst_mid");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        async_reset("rnd_rst");
      end else begin
        stall    = ($urandom_range(3) == 0);
        trap     = ($urandom_range(19) == 0);
        trap_ret = ($urandom_range(19) == 0);
        enl      = ($urandom_range(5) == 0);
        call     = ($urandom_range(2) == 0);
        ret      = ($urandom_range(2) == 0);
        load     = $urandom;
        if ($urandom_range(3) != 0) load[1:0] = 2'b00;
        cycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
